dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Multi-cycle data-memory responder: the target side of the load/store request issued by the pipeline's memory stage.
- Accepts one request at a time over a valid/ready handshake and holds it for a configurable access latency.
- Performs word, halfword or byte reads and writes on a word-organised array with lane placement and sign/zero extension.
- Returns the result over a valid/ready response handshake and flags misaligned or out-of-range accesses.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in the array; valid byte addresses are 0 .. DEPTH_WORDS*4-1.
- LATENCY, 2, cycles spent in BUSY before the access commits; legal range 1..15.

Ports:
- clk  in  1  system clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  size/extension: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned. Other codes are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, taken from the low bits for byte and half stores.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request was misaligned, out of range, or used an illegal op.

Behaviour:
- Reset:
  - Clears every array word to 0.
  - State goes to IDLE.
  - req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0.
- States are IDLE, BUSY and RESP.
- IDLE:
  - req_ready=1.
  - On the edge where req_valid&&req_ready, latch we/op/addr/wdata, load cnt=LATENCY-1 and go to BUSY.
- BUSY:
  - req_ready=0.
  - If cnt!=0, decrement cnt.
  - If cnt==0, commit the access on this edge, load the response registers and go to RESP.
- RESP:
  - resp_valid=1; req_ready=0.
  - resp_rdata and resp_err stay stable until handshake.
  - On resp_valid&&resp_ready, go to IDLE and clear resp_valid, resp_rdata and resp_err.
  - A new request cannot be accepted on the same edge; minimum request-to-request spacing is LATENCY+2 cycles.
- Latency: request accepted at edge T → resp_valid high in the cycle after edge T+LATENCY.
- Word index = addr[31:2].
- Error checks:
  - Misaligned: word with addr[1:0]!=0, or half with addr[0]!=0.
  - Out of range: addr >= DEPTH_WORDS*4.
  - Illegal op code.
  - On error: no array write, resp_err=1, resp_rdata=0.
- Stores (size from op; the extension bit is ignored):
  - Word: writes all 32 bits.
  - Half: writes wdata[15:0] into bits [15:0] if addr[1]=0, else [31:16].
  - Byte: writes wdata[7:0] into lane addr[1:0]; lane 0 = bits [7:0].
  - Untouched lanes keep their value.
  - resp_rdata=0.
- Loads:
  - Select the lane as for stores.
  - Sign-extend or zero-extend to 32 bits according to op.
  - Read data is the array contents at the commit edge.
- Reset mid-operation:
  - In BUSY: the pending store is dropped and the array is cleared.
  - In RESP: the response is discarded.
  - The next cycle is IDLE with all outputs at reset values.
- req_valid while not ready is ignored; the requester must hold the request.
- Inputs other than req_valid, and resp_ready outside RESP, have no effect.

Test Plan:
- Reset, then sw addr=0x10 wdata=0xDEADBEEF with LATENCY=2 → resp_valid high 2 cycles after acceptance, err=0. Next lw 0x10 → rdata=0xDEADBEEF.
- After the word above: sb 0x12 wdata=0x000000AA, then lw 0x10 → 0xDEAABEEF. Also lb 0x12 → 0xFFFFFFAA; lbu 0x12 → 0x000000AA.
- sh 0x16 wdata=0x8001 onto a zero word, then lh 0x16 → 0xFFFF8001; lhu 0x16 → 0x00008001; lw 0x14 → 0x80010000.
- Error cases:
  - lw 0x11 → err=1, rdata=0.
  - sw 0x3000 (DEPTH 3072) → err=1, and a later lw 0x0 is unchanged.
  - op=111 → err=1.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and rdata stable, req_ready=0. A req_valid pulse during this time is not accepted.
- Assert reset in the BUSY cycle of sw 0x20=0x12345678 → next cycle IDLE, req_ready=1, and lw 0x20 → 0.

Source files
------------

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, commits to a word array with byte/half lane handling, then returns a response.
module dm_responder #(
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic             commit_err;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;

  function automatic logic access_err(input logic [2:0] op, input logic [31:0] addr);
    logic bad_op, misal;
    bad_op = (op > 3'd4);
    misal  = ((op == 3'd0) && (addr[1:0] != 2'd0)) ||
             (((op == 3'd3) || (op == 3'd4)) && addr[0]);
    return bad_op || misal || (addr >= ADDR_LIMIT);
  endfunction

  // Replace only the lanes addressed by the store; other lanes keep the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [2:0] op,
                                              input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (op)
      3'd1, 3'd2: r[{lane, 3'b000} +: 8]     = wd[7:0];
      3'd3, 3'd4: r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default:    r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] op,
                                               input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (op)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'd0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  assign commit_err = access_err(op_q, addr_q);
  assign word_idx   = addr_q[IDX_W+1:2];
  assign rd_word    = mem[word_idx];
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)     state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0)   state_nxt = RESP;
      RESP:    if (resp_ready)    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Request latch, latency countdown, commit and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          op_q    <= req_op;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt     <= 4'(LATENCY - 1);
        end
        BUSY: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (commit_err) begin
          resp_err   <= 1'b1;
          resp_rdata <= 32'd0;
        end else if (we_q) begin
          mem[word_idx] <= store_merge(rd_word, op_q, addr_q[1:0], wdata_q);
          resp_err      <= 1'b0;
          resp_rdata    <= 32'd0;
        end else begin
          resp_err   <= 1'b0;
          resp_rdata <= load_extract(rd_word, op_q, addr_q[1:0]);
        end
        RESP: if (resp_ready) begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: scoreboard of expected responses, immediate-assertion checks.
module tb_dm_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 3072;
  localparam int BOUND = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: push the expectation, handshake the request, measure latency,
  // optionally stall the response for `hold` cycles with a stray request pulse.
  task automatic txn(input string tag, input logic we, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    exp_t e;
    int   n;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    n = 0;
    while (!req_ready && n < BOUND) begin tick(); n++; end
    check({tag, ".ready_timeout"}, 32'(n < BOUND), 32'd1);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < BOUND) begin tick(); n++; end
    check({tag, ".latency"}, 32'(n), 32'(LAT));
    e = sb.pop_front();
    check({tag, ".rdata"}, resp_rdata, e.rdata);
    check({tag, ".err"}, 32'(resp_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'd0;
        req_addr = 32'h40; req_wdata = 32'h55;
      end
      tick();
      req_valid = 1'b0;
      check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".hold_rdata"}, resp_rdata, e.rdata);
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".post_rdata"}, resp_rdata, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);

    txn("sw10",  1'b1, 3'd0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    txn("lw10",  1'b0, 3'd0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    txn("sb12",  1'b1, 3'd2, 32'h12, 32'h000000AA, 32'h0,        1'b0, 0);
    txn("lw10b", 1'b0, 3'd0, 32'h10, 32'h0,        32'hDEAABEEF, 1'b0, 0);
    txn("lb12",  1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFFFFAA, 1'b0, 0);
    txn("lbu12", 1'b0, 3'd2, 32'h12, 32'h0,        32'h000000AA, 1'b0, 0);
    txn("lb13",  1'b0, 3'd1, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 0);
    txn("sh16",  1'b1, 3'd3, 32'h16, 32'h00008001, 32'h0,        1'b0, 0);
    txn("lh16",  1'b0, 3'd3, 32'h16, 32'h0,        32'hFFFF8001, 1'b0, 0);
    txn("lhu16", 1'b0, 3'd4, 32'h16, 32'h0,        32'h00008001, 1'b0, 0);
    txn("lw14",  1'b0, 3'd0, 32'h14, 32'h0,        32'h80010000, 1'b0, 0);
    txn("lh14",  1'b0, 3'd3, 32'h14, 32'h0,        32'h00000000, 1'b0, 0);

    txn("lw11",    1'b0, 3'd0, 32'h11,   32'h0,        32'h0,        1'b1, 0);
    txn("lh13",    1'b0, 3'd3, 32'h13,   32'h0,        32'h0,        1'b1, 0);
    txn("sw0",     1'b1, 3'd0, 32'h0,    32'h11223344, 32'h0,        1'b0, 0);
    txn("sw3000",  1'b1, 3'd0, 32'h3000, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
    txn("lw0",     1'b0, 3'd0, 32'h0,    32'h0,        32'h11223344, 1'b0, 0);
    txn("op7",     1'b0, 3'd7, 32'h10,   32'h0,        32'h0,        1'b1, 0);
    txn("st_op5",  1'b1, 3'd5, 32'h10,   32'h0,        32'h0,        1'b1, 0);
    txn("lw10c",   1'b0, 3'd0, 32'h10,   32'h0,        32'hDEAABEEF, 1'b0, 0);
    txn("sb2fff",  1'b1, 3'd1, 32'h2FFF, 32'h0000007F, 32'h0,        1'b0, 0);
    txn("lw2ffc",  1'b0, 3'd0, 32'h2FFC, 32'h0,        32'h7F000000, 1'b0, 0);

    txn("hold",    1'b0, 3'd0, 32'h10,   32'h0,        32'hDEAABEEF, 1'b0, 5);
    txn("lw40",    1'b0, 3'd0, 32'h40,   32'h0,        32'h0,        1'b0, 0);

    // Reset while the store to 0x20 sits in BUSY.
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'd0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    tick();
    req_valid = 1'b0;
    check("busy.req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.req_ready", 32'(req_ready), 32'd1);
    check("midrst.resp_valid", 32'(resp_valid), 32'd0);
    check("midrst.resp_rdata", resp_rdata, 32'd0);
    check("midrst.resp_err", 32'(resp_err), 32'd0);
    txn("lw20",   1'b0, 3'd0, 32'h20, 32'h0, 32'h0, 1'b0, 0);
    txn("lw10rs", 1'b0, 3'd0, 32'h10, 32'h0, 32'h0, 1'b0, 0);

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
